// File: rtl/pw_change_ctrl.sv
// Change-password session controller for the 10-slot password register bank.
// Optional inactivity timeout is built when PWCHG_TIMEOUT_EN is defined.
module pw_change_ctrl #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCK_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  user_sel,
  input  logic        enter,
  input  logic        cancel,
  input  logic [15:0] digits,
  input  logic [15:0] stored_pw,
  output logic [3:0]  rd_sel,
  output logic [9:0]  wr_en,
  output logic [15:0] wr_digits,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic        locked
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VERIFY,
    S_NEW,
    S_CONFIRM,
    S_COMMIT,
    S_LOCKED
  } state_e;

  localparam int unsigned      LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]        TRIES_MAX = 4'(MAX_TRIES);

  state_e            state_q, state_d;
  logic [3:0]        rd_sel_q, rd_sel_d;
  logic [3:0]        tries_q, tries_d;
  logic [15:0]       new_pw_q, new_pw_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              fail_q, fail_d;
  logic [9:0]        wr_en_q, wr_en_d;
  logic [15:0]       wr_digits_q, wr_digits_d;
  logic              in_session;

`ifdef PWCHG_TIMEOUT_EN
  localparam int unsigned      TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  function automatic logic all_bcd(input logic [15:0] d);
    return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9) &&
           (d[11:8] <= 4'd9) && (d[15:12] <= 4'd9);
  endfunction

  assign in_session = (state_q == S_VERIFY) || (state_q == S_NEW) || (state_q == S_CONFIRM);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    rd_sel_d    = rd_sel_q;
    tries_d     = tries_q;
    new_pw_d    = new_pw_q;
    lock_cnt_d  = '0;
    fail_d      = 1'b0;
    wr_en_d     = '0;
    wr_digits_d = '0;
`ifdef PWCHG_TIMEOUT_EN
    to_cnt_d    = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (user_sel >= 4'd1 && user_sel <= 4'd10) begin
            rd_sel_d = user_sel;
            state_d  = S_VERIFY;
          end else begin
            fail_d = 1'b1;
          end
        end
      end

      S_VERIFY: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (enter) begin
          if (digits == stored_pw) begin
            tries_d = '0;
            state_d = S_NEW;
          end else begin
            tries_d = tries_q + 4'd1;
            fail_d  = 1'b1;
            if (tries_q + 4'd1 == TRIES_MAX) state_d = S_LOCKED;
          end
        end
      end

      S_NEW: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (enter) begin
          if (all_bcd(digits)) begin
            new_pw_d = digits;
            state_d  = S_CONFIRM;
          end else begin
            fail_d = 1'b1;
          end
        end
      end

      S_CONFIRM: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (enter) begin
          if (digits == new_pw_q) begin
            // Strobe and data are registered so they coincide with the COMMIT cycle.
            state_d     = S_COMMIT;
            wr_en_d     = 10'd1 << (rd_sel_q - 4'd1);
            wr_digits_d = new_pw_q;
          end else begin
            fail_d   = 1'b1;
            new_pw_d = '0;
            state_d  = S_NEW;
          end
        end
      end

      S_COMMIT: state_d = S_IDLE;

      S_LOCKED: begin
        if (lock_cnt_q == LOCK_LAST) begin
          tries_d = '0;
          state_d = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef PWCHG_TIMEOUT_EN
    // A quiet cycle in a session means no enter and no cancel, so the state is holding.
    if (in_session && !enter && !cancel) begin
      if (to_cnt_q == TO_LAST) begin
        fail_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignment so all flops update from pre-edge values.
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_sel_q    <= '0;
      tries_q     <= '0;
      new_pw_q    <= '0;
      lock_cnt_q  <= '0;
      fail_q      <= 1'b0;
      wr_en_q     <= '0;
      wr_digits_q <= '0;
`ifdef PWCHG_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_sel_q    <= rd_sel_d;
      tries_q     <= tries_d;
      new_pw_q    <= new_pw_d;
      lock_cnt_q  <= lock_cnt_d;
      fail_q      <= fail_d;
      wr_en_q     <= wr_en_d;
      wr_digits_q <= wr_digits_d;
`ifdef PWCHG_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign rd_sel    = rd_sel_q;
  assign wr_en     = wr_en_q;
  assign wr_digits = wr_digits_q;
  assign fail      = fail_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_COMMIT);
  assign locked    = (state_q == S_LOCKED);

endmodule
